// File: rtl/ice40_ebr_fifo_ctl_if.sv
// FIFO user-side handshake bundle: push/pop requests, head data and occupancy flags.
// The master modport is the producer/consumer; the slave modport is the FIFO controller.
interface ice40_ebr_fifo_ctl_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic [DW-1:0] wr_data;
   logic          wr_ena;
   logic          full;
   logic [DW-1:0] rd_data;
   logic          rd_ena;
   logic          empty;
   logic [AW+1:0] level;

   modport master (
      output wr_data,
      output wr_ena,
      output rd_ena,
      input  full,
      input  rd_data,
      input  empty,
      input  level
   );

   modport slave (
      input  wr_data,
      input  wr_ena,
      input  rd_ena,
      output full,
      output rd_data,
      output empty,
      output level
   );
endinterface

// File: rtl/ice40_ebr_fifo_ctl.sv
// First-word-fall-through FIFO controller driving both ports of one ice40_ebr.
// Storage lives in the EBR; the EBR output register acts as the one-word head latch.
module ice40_ebr_fifo_ctl #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ice40_ebr_fifo_ctl_if.slave   fifo,
   output logic [AW-1:0]         ebr_wr_addr,
   output logic [DW-1:0]         ebr_wr_data,
   output logic                  ebr_wr_ena,
   output logic [AW-1:0]         ebr_rd_addr,
   output logic                  ebr_rd_ena,
   input  logic [DW-1:0]         ebr_rd_data
);

   localparam logic [AW:0] RAM_DEPTH = {1'b1, {AW{1'b0}}};

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   ram_cnt_q, ram_cnt_d;
   logic          head_vld_q, head_vld_d;

   logic          full;
   logic          push;
   logic          pop;
   logic          fetch;

   // A prefetch is issued whenever the head latch is free or being vacated this cycle.
   always_comb begin
      full       = (ram_cnt_q == RAM_DEPTH);
      push       = fifo.wr_ena & ~full;
      pop        = fifo.rd_ena & head_vld_q;
      fetch      = (ram_cnt_q != '0) & (~head_vld_q | pop);

      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(fetch);
      ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(fetch);
      head_vld_d = fetch | (head_vld_q & ~pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         head_vld_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         head_vld_q <= head_vld_d;
      end
   end

   // The EBR holds its output while rd_ena is low, so its read data is the head word.
   always_comb begin
      ebr_wr_ena   = push;
      ebr_wr_addr  = wr_ptr_q;
      ebr_wr_data  = fifo.wr_data;
      ebr_rd_ena   = fetch;
      ebr_rd_addr  = rd_ptr_q;

      fifo.full    = full;
      fifo.empty   = ~head_vld_q;
      fifo.rd_data = ebr_rd_data;
      fifo.level   = {1'b0, ram_cnt_q} + (AW+2)'(head_vld_q);
   end

endmodule

// File: doc/ice40_ebr_fifo_ctl.md
Name: ice40_ebr_fifo_ctl

Overview:
- Single-clock, first-word-fall-through FIFO controller that drives one ice40_ebr instance in the same read/write mode.
- Sits directly upstream of that EBR and owns both of its ports: it generates write addresses and enables, issues prefetch reads, and presents the EBR read output as FIFO head data.
- Pointer, count and flag logic lives here; storage is entirely in the EBR.

Parameters:
- AW, 8: EBR address width; RAM capacity is 2^AW words. Must equal the ice40_ebr WAW and RAW, so read mode equals write mode.
- DW, 16: data width. Must equal the ice40_ebr WDW and RDW.

Ports:
- clk  in  1  single clock; also drives the EBR wr_clk and rd_clk.
- rst_n  in  1  asynchronous, active-low reset.
- wr_data  in  DW  write data.
- wr_ena  in  1  write request.
- full  out  1  write rejected when high.
- rd_data  out  DW  head word; valid while empty=0.
- rd_ena  in  1  pop request.
- empty  out  1  no head word available.
- level  out  AW+2  total words held, range 0..2^AW+1.
- ebr_wr_addr  out  AW  to ice40_ebr wr_addr.
- ebr_wr_data  out  DW  to ice40_ebr wr_data.
- ebr_wr_ena  out  1  to ice40_ebr wr_ena.
- ebr_rd_addr  out  AW  to ice40_ebr rd_addr.
- ebr_rd_ena  out  1  to ice40_ebr rd_ena.
- ebr_rd_data  in  DW  from ice40_ebr rd_data.
- The integrator ties the ice40_ebr wr_mask to all zeros (all bits written).

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, ram_cnt=0, head_vld=0. Resulting outputs: empty=1, full=0, level=0, ebr_wr_ena=0, ebr_rd_ena=0. Reset is effective immediately, including mid-operation. Contents held in the EBR are discarded.
- Internal state: wr_ptr and rd_ptr (AW bits, natural wrap at 2^AW); ram_cnt (AW+1 bits, 0..2^AW) = words in RAM not yet fetched; head_vld = EBR output latch holds an unpopped word.
- full = (ram_cnt == 2^AW), from registered state only, with no same-cycle bypass.
- empty = !head_vld.
- level = ram_cnt + head_vld.
- Write side:
  - push = wr_ena & !full.
  - ebr_wr_ena = push, combinational. ebr_wr_addr = wr_ptr. ebr_wr_data = wr_data.
  - On push, wr_ptr increments.
  - wr_ena while full is dropped silently; no pointer or count change.
- Read side:
  - pop = rd_ena & head_vld. rd_ena while empty is ignored.
  - fetch = (ram_cnt != 0) & (!head_vld | pop).
  - ebr_rd_ena = fetch, combinational. ebr_rd_addr = rd_ptr. On fetch, rd_ptr increments.
  - The EBR has 1-cycle read latency and holds its output while rd_ena is low, so rd_data = ebr_rd_data directly.
  - head_vld next = fetch | (head_vld & !pop).
- ram_cnt next = ram_cnt + push - fetch. A simultaneous push and fetch leaves it unchanged.
- Throughput: sustained 1 push and 1 pop per cycle with no bubbles once head_vld=1.
- Write-to-read latency into an empty FIFO:
  - push at cycle T; ram_cnt=1 at T+1 and fetch issues.
  - empty falls and rd_data is valid at T+2.
- Read/write address collision cannot occur: fetch requires ram_cnt>0, so rd_ptr != wr_ptr unless full, and no push happens while full.
- Capacity is 2^AW words in RAM plus 1 in the head latch. full means RAM full; the head may still be occupied.
- Pop while full: fetch frees a RAM slot. full falls the next cycle; a wr_ena in the same cycle is still rejected.

Test Plan:
- Reset with AW=4, DW=16 -> empty=1, full=0, level=0, ebr_wr_ena=0, ebr_rd_ena=0.
- Push 0xA5A5 at cycle T into an empty FIFO -> ebr_wr_ena=1 with addr 0 at T; ebr_rd_ena=1 with addr 0 at T+1; empty=0 and rd_data=0xA5A5 at T+2; level: 1 at T+1 and at T+2.
- Push 17 words 0x0000..0x0010 with no pops -> full=1 and level=17 afterwards; an 18th push gives ebr_wr_ena=0 and no change. Then pop 17 times on consecutive cycles -> rd_data sequence 0x0000..0x0010 in order, no bubbles, then empty=1 and level=0.
- Steady streaming: push and pop every cycle for 100 cycles with incrementing data -> output is in order, level stays constant, pointers wrap through 15->0 cleanly.
- Ignore cases: rd_ena=1 while empty -> no fetch, rd_ptr unchanged. With full=1, assert wr_ena and rd_ena in the same cycle -> pop accepted, write rejected, full=0 next cycle.
- Assert rst_n low mid-stream with level=9 -> outputs are at reset values immediately. After release, a new push of 0x1234 is read back first, 2 cycles later, at address 0.
